// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan controller with a double-buffered pattern bank.
// Shadow writes become visible only when a commit is applied at a frame boundary or while idle.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 6,
   parameter int unsigned CLK_DIV      = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       commit,
   input  logic [5:0] digit_mask,
   output logic [2:0] bit_disp,
   output logic [7:0] seg_data,
   output logic       frame_done,
   output logic       commit_pending
);

   localparam int unsigned CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [2:0]    LAST_IDX   = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BLANK,
      ST_SHOW
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    r_idx;
   logic [2:0]    w_idx_nxt;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    w_seg_nxt;
   logic          w_fd_nxt;
   logic          w_pend_nxt;
   logic          w_load;
   logic          w_addr_ok;
   logic [7:0]    w_mask8;

   // Banks are sized to the full 3-bit address space; entries beyond NUM_DIGITS stay at reset value.
   logic [7:0]    r_shadow [8];
   logic [7:0]    r_active [8];

   assign w_addr_ok = (32'(wr_addr) < NUM_DIGITS);
   assign w_mask8   = {2'b00, digit_mask};

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_bit_nxt   = bit_disp;
      w_seg_nxt   = seg_data;
      w_fd_nxt    = 1'b0;
      w_pend_nxt  = commit_pending | commit;
      w_load      = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_bit_nxt  = 3'b111;
            w_seg_nxt  = '1;
            w_cnt_nxt  = '0;
            w_idx_nxt  = '0;
            w_load     = commit_pending | commit;
            w_pend_nxt = 1'b0;
            if (enable) begin
               w_state_nxt = ST_BLANK;
            end
         end
         ST_BLANK: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_bit_nxt   = 3'b111;
               w_seg_nxt   = '1;
            end else if (r_cnt == BLANK_LAST) begin
               w_state_nxt = ST_SHOW;
               w_cnt_nxt   = '0;
               if (w_mask8[r_idx]) begin
                  w_bit_nxt = r_idx;
                  w_seg_nxt = r_active[r_idx];
               end else begin
                  w_bit_nxt = 3'b111;
                  w_seg_nxt = '1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_SHOW: begin
            if (!enable) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_bit_nxt   = 3'b111;
               w_seg_nxt   = '1;
            end else if (r_cnt == SHOW_LAST) begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_bit_nxt   = 3'b111;
               w_seg_nxt   = '1;
               if (r_idx == LAST_IDX) begin
                  // Frame boundary: a commit arriving on this same edge stays pending for the next one.
                  w_idx_nxt  = '0;
                  w_fd_nxt   = 1'b1;
                  w_load     = commit_pending;
                  w_pend_nxt = commit;
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_idx          <= '0;
         bit_disp       <= 3'b111;
         seg_data       <= '1;
         frame_done     <= 1'b0;
         commit_pending <= 1'b0;
         for (int unsigned i = 0; i < 8; i++) begin
            r_shadow[i] <= '1;
            r_active[i] <= '1;
         end
      end else begin
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_idx          <= w_idx_nxt;
         bit_disp       <= w_bit_nxt;
         seg_data       <= w_seg_nxt;
         frame_done     <= w_fd_nxt;
         commit_pending <= w_pend_nxt;
         if (w_load) begin
            for (int unsigned i = 0; i < 8; i++) begin
               r_active[i] <= r_shadow[i];
            end
         end
         if (wr_en && w_addr_ok) begin
            r_shadow[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 6-digit seven-segment display.
- Holds a double-buffered segment-pattern bank written by the SoC peripheral side.
- Steps a digit index through the digits with a programmable dwell time and an inter-digit blanking gap to suppress ghosting.
- Drives the 3-bit digit index into the digit-select decoder, together with the matching segment pattern. Index 3'b111 means "all digits off".

Parameters:
- NUM_DIGITS, 6, number of scanned digits; legal range 1..6.
- CLK_DIV, 50000, clk cycles each digit is shown (SHOW dwell); must be >= 1.
- BLANK_CYCLES, 16, clk cycles all digits are off before each digit is shown; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  scan enable; low forces display off.
- wr_en  input  1  write strobe for the shadow bank.
- wr_addr  input  3  shadow digit address; 0..NUM_DIGITS-1 valid, others ignored.
- wr_data  input  8  segment pattern {dp,g,f,e,d,c,b,a}, active-low (0 = lit).
- commit  input  1  one-cycle pulse: request shadow -> active copy.
- digit_mask  input  6  per-digit enable; bit i = 0 keeps digit i dark during its slot.
- bit_disp  output  3  digit index to the select decoder; 3'b111 = none.
- seg_data  output  8  segment pattern for the current digit; 8'hFF = off.
- frame_done  output  1  one-cycle pulse at the end of each full scan frame.
- commit_pending  output  1  high while a commit request is waiting for the frame boundary.

Behaviour:
- Reset (rst=1 at a clock edge) has priority over all other inputs:
  - state = IDLE, digit index = 0, dwell counter = 0.
  - Shadow and active banks = 8'hFF.
  - bit_disp = 3'b111, seg_data = 8'hFF, frame_done = 0, commit_pending = 0.
  - Reset mid-scan takes effect on the same edge.
- Shadow bank:
  - wr_en=1 with wr_addr < NUM_DIGITS writes wr_data to shadow[wr_addr] at the edge.
  - Writes to other addresses are dropped.
  - Writes never alter the displayed pattern directly.
- All outputs are registered and change on the same edge as the state/counter they reflect.
- States: IDLE, BLANK, SHOW.
  - IDLE:
    - Outputs are off.
    - A commit is applied immediately: the active bank is loaded next edge and commit_pending stays 0.
    - When enable=1: next edge -> BLANK, digit index = 0, counter = 0.
  - BLANK:
    - Outputs are off; the counter increments each cycle.
    - When counter = BLANK_CYCLES-1: -> SHOW, counter = 0.
    - In SHOW, bit_disp = index and seg_data = active[index] if digit_mask[index]=1; otherwise outputs stay off.
  - SHOW:
    - Outputs hold; the counter increments.
    - When counter = CLK_DIV-1: -> BLANK, counter = 0, outputs off.
    - If index < NUM_DIGITS-1, index increments.
    - Else (end of frame) index wraps to 0 and frame_done pulses high for that one cycle.
    - If commit_pending=1 at that point, the active bank is loaded from shadow and commit_pending clears, all on the same edge.
- Commit while scanning (BLANK or SHOW) sets commit_pending.
  - Commit on the exact frame-boundary edge is captured as pending for the next boundary; it is not lost.
  - Repeated commits while pending are idempotent.
  - Shadow writes made after a commit but before the boundary are included in the copy (the copy takes the shadow contents at the boundary).
- enable=0 in BLANK or SHOW:
  - Next edge -> IDLE, outputs off, index and counter = 0.
  - commit_pending is kept and is applied on the IDLE cycle.
- Timing:
  - Frame period = NUM_DIGITS*(BLANK_CYCLES+CLK_DIV) cycles.
  - Latency from enable rising (sampled) to first lit digit = 1 + BLANK_CYCLES cycles.
- Counter width = clog2 of max(CLK_DIV, BLANK_CYCLES), minimum 1. The counter never exceeds its terminal value.
- bit_disp never presents 3'b110; the only values are 0..NUM_DIGITS-1 and 3'b111.

Test Plan (NUM_DIGITS=6, CLK_DIV=4, BLANK_CYCLES=2 unless noted):
- Reset and idle: rst for 2 cycles, enable=0 -> bit_disp=3'b111, seg_data=8'hFF, frame_done=0, commit_pending=0 indefinitely.
- Basic scan:
  - Stimulus: write shadow[i]=8'hC0+i, commit in IDLE, then enable=1.
  - Response: after 3 cycles bit_disp=0 with seg_data=8'hC0 for 4 cycles, then 2 cycles of 3'b111/8'hFF, then bit_disp=1 with 8'hC1, and so on.
  - frame_done pulses every 36 cycles; digit order wraps 5 -> 0.
- Double buffering:
  - Stimulus: mid-frame (digit 2 lit), write shadow[0]=8'hF9 and pulse commit.
  - Response: commit_pending=1; digits 3..5 still show old data; the active bank updates on the frame_done edge; the next digit 0 shows 8'hF9; commit_pending returns to 0.
- Masking and invalid address:
  - Stimulus: digit_mask=6'b111011; write with wr_addr=6.
  - Response: during digit 2's slot bit_disp=3'b111 and seg_data=8'hFF; slot timing is unchanged; the addr-6 write has no effect on any digit.
- Enable drop and reset mid-operation:
  - Stimulus: enable=0 while in SHOW with digit 4 and a commit pending.
  - Response: next cycle bit_disp=3'b111 and the active bank is updated on the following edge; enable=1 restarts at digit 0 after 3 cycles.
  - Repeat with rst=1 instead: all outputs reset on that edge, and both banks read 8'hFF.
- Edge parameters: NUM_DIGITS=1, CLK_DIV=1, BLANK_CYCLES=1 -> bit_disp alternates 3'b111/0 every cycle; frame_done pulses every 2 cycles.
